ex_alu_stage: RTL and testbench

- Registered execute-stage ALU that consumes decoded operands from ID/EX and produces one 16-bit result plus the N/Z/V flag register for the branch unit.
- Wraps the 16-bit adder/sub-word adder datapath behind a valid/ready handshake with a one-deep output register.
- RED is multi-cycle; all other ops complete in one cycle.

---
 rtl/ex_alu_stage.sv | 211 +++++++++++++++++++++
 tb/tb_ex_alu_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// ex_alu_stage - registered execute-stage ALU with a valid/ready handshake
// and a one-deep output register.
//
// Single-cycle ops: ADD/SUB (saturating), XOR, SLL, SRA, ROR, PADDSB
// (per-nibble saturating add) and illegal opcodes. RED (signed byte
// reduction) takes two cycles: the byte sums are latched on accept and
// combined in the RED2 state.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   in_valid   operand bundle valid
//   in_ready   stage can accept a bundle this cycle
//   opcode     operation select (see op_e)
//   A, B       operands; shifts use B[3:0] as the amount
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream accepts the result
//   result     registered result
//   flags      {N,Z,V} flag register
module ex_alu_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RED2
    } state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;
    logic [8:0]       s1_q, s1_d;
    logic [8:0]       s0_q, s0_d;

    logic             out_free;
    logic             accept;
    logic             is_sub;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [WIDTH-1:0] add_sat;
    logic [3:0]       shamt;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_flags;
    logic [8:0]       red_s1;
    logic [8:0]       red_s0;
    logic [9:0]       red_sum;
    logic [WIDTH-1:0] red_ext;

    // Four independent signed nibble adds, each clamped to [-8,+7].
    function automatic logic [15:0] paddsb(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  na;
        logic [3:0]  nb;
        logic [4:0]  s;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            s  = {na[3], na} + {nb[3], nb};
            if (s[4] != s[3]) begin
                r[4*i +: 4] = s[4] ? 4'h8 : 4'h7;
            end else begin
                r[4*i +: 4] = s[3:0];
            end
        end
        return r;
    endfunction

    // The output register can take a new value when it is empty or being drained.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = rst_n && (state_q == S_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    assign shamt = B[3:0];

    // Shared adder: SUB is A + ~B + 1, overflow judged on the inverted operand.
    always_comb begin
        is_sub  = (opcode == OP_SUB);
        addend  = is_sub ? ~B : B;
        sum     = A + addend + {{(WIDTH-1){1'b0}}, is_sub};
        add_ovf = (A[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        if (add_ovf) begin
            add_sat = A[WIDTH-1] ? 16'h8000 : 16'h7FFF;
        end else begin
            add_sat = sum;
        end
    end

    // RED partial sums (9-bit signed) and the final 10-bit signed combine.
    assign red_s1  = {A[15], A[15:8]} + {B[15], B[15:8]};
    assign red_s0  = {A[7], A[7:0]} + {B[7], B[7:0]};
    assign red_sum = {s1_q[8], s1_q} + {s0_q[8], s0_q};
    assign red_ext = {{6{red_sum[9]}}, red_sum};

    always_comb begin
        alu_res   = '0;
        alu_flags = flags_q;
        case (opcode)
            OP_ADD, OP_SUB: begin
                alu_res   = add_sat;
                alu_flags = {add_sat[WIDTH-1], (add_sat == '0), add_ovf};
            end
            OP_XOR: begin
                alu_res      = A ^ B;
                alu_flags[1] = (alu_res == '0);
            end
            OP_SLL: begin
                alu_res      = A << shamt;
                alu_flags[1] = (alu_res == '0);
            end
            OP_SRA: begin
                alu_res      = $signed(A) >>> shamt;
                alu_flags[1] = (alu_res == '0);
            end
            OP_ROR: begin
                // A left shift by 16 yields zero, so shamt==0 passes A through.
                alu_res      = (A >> shamt) | (A << (5'd16 - {1'b0, shamt}));
                alu_flags[1] = (alu_res == '0);
            end
            OP_PADDSB: begin
                alu_res = paddsb(A, B);
            end
            default: begin
                // RED is finished in RED2; illegal opcodes produce zero.
                alu_res = '0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        s1_d        = s1_q;
        s0_d        = s0_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_RED) begin
                        s1_d    = red_s1;
                        s0_d    = red_s0;
                        state_d = S_RED2;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_RED2: begin
                if (out_free) begin
                    result_d    = red_ext;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            s1_q        <= '0;
            s0_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    ex_alu_stage #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    typedef struct {
        logic [15:0] r;
        logic [2:0]  f;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [2:0]  f;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        tbl[22];
    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    bit          bp = 1'b0;
    logic [2:0]  mflags = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model, written independently of the RTL datapath.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] fin, output logic [15:0] r, output logic [2:0] f);
        int s;
        int x;
        int n;
        r = '0;
        f = fin;
        n = int'(b[3:0]);
        case (op)
            4'd0, 4'd1: begin
                if (op == 4'd0) s = int'($signed(a)) + int'($signed(b));
                else            s = int'($signed(a)) - int'($signed(b));
                if (s > 32767)       r = 16'h7FFF;
                else if (s < -32768) r = 16'h8000;
                else                 r = s[15:0];
                f = {r[15], r == 16'h0000, (s > 32767) || (s < -32768)};
            end
            4'd2: begin
                r = a ^ b;
                f = {fin[2], r == 16'h0000, fin[0]};
            end
            4'd3: begin
                s = int'($signed(a[15:8])) + int'($signed(b[15:8]))
                  + int'($signed(a[7:0])) + int'($signed(b[7:0]));
                r = s[15:0];
            end
            4'd4: begin
                r = a;
                repeat (n) r = {r[14:0], 1'b0};
                f[1] = (r == 16'h0000);
            end
            4'd5: begin
                r = a;
                repeat (n) r = {r[15], r[15:1]};
                f[1] = (r == 16'h0000);
            end
            4'd6: begin
                r = a;
                repeat (n) r = {r[0], r[15:1]};
                f[1] = (r == 16'h0000);
            end
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    x = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
                    if (x > 7) x = 7;
                    else if (x < -8) x = -8;
                    r[4*i +: 4] = x[3:0];
                end
            end
            default: r = '0;
        endcase
    endtask

    // Drive one bundle at the falling edge, wait (bounded) for in_ready, and
    // return just after the accepting rising edge. in_valid is left high.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit push, input logic [15:0] er, input logic [2:0] ef);
        int waited = 0;
        @(negedge clk);
        if (bp) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        opcode   = op;
        A        = a;
        B        = b;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            if (bp) out_ready = 1'($urandom_range(0, 1));
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready=%b for op %h, required 1", in_ready, op);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_cyc = cyc;
        if (push) sb.push_back('{r: er, f: ef});
    endtask

    task automatic issue_m(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [2:0]  f;
        model(op, a, b, mflags, r, f);
        issue(op, a, b, 1'b1, r, f);
        mflags = f;
    endtask

    task automatic drain();
        int k = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every transferred result in order.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got result %h with no pending op, required none", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.r);
                check("flags", flags, mon_e.f);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned a0;
        logic [15:0] r;
        logic [2:0]  f;
        logic [3:0]  rop;

        //            op     A         B         result    {N,Z,V}
        tbl[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001};
        tbl[1]  = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 3'b101};
        tbl[2]  = '{4'h0, 16'h0005, 16'hFFFB, 16'h0000, 3'b010};
        tbl[3]  = '{4'h7, 16'h7878, 16'h1188, 16'h79F8, 3'b010};
        tbl[4]  = '{4'h2, 16'h1234, 16'h1234, 16'h0000, 3'b010};
        tbl[5]  = '{4'h4, 16'h0001, 16'h000F, 16'h8000, 3'b000};
        tbl[6]  = '{4'h5, 16'h8000, 16'h0004, 16'hF800, 3'b000};
        tbl[7]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b000};
        tbl[8]  = '{4'h6, 16'h1234, 16'h0000, 16'h1234, 3'b000};
        tbl[9]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, 3'b100};
        tbl[10] = '{4'h2, 16'hFFFF, 16'h0000, 16'hFFFF, 3'b100};
        tbl[11] = '{4'h0, 16'h8000, 16'h8000, 16'h8000, 3'b101};
        tbl[12] = '{4'h8, 16'h0001, 16'h0001, 16'h0000, 3'b101};
        tbl[13] = '{4'h1, 16'h0000, 16'h8000, 16'h7FFF, 3'b001};
        tbl[14] = '{4'h5, 16'h7FF0, 16'h0004, 16'h07FF, 3'b001};
        tbl[15] = '{4'h4, 16'hFFFF, 16'h0010, 16'hFFFF, 3'b001};
        tbl[16] = '{4'h7, 16'h8888, 16'h8888, 16'h8888, 3'b001};
        tbl[17] = '{4'h7, 16'h1234, 16'h4321, 16'h5555, 3'b001};
        tbl[18] = '{4'h3, 16'h7F7F, 16'h7F7F, 16'h01FC, 3'b001};
        tbl[19] = '{4'h3, 16'h8080, 16'h8080, 16'hFE00, 3'b001};
        tbl[20] = '{4'h3, 16'h0102, 16'hFF01, 16'h0003, 3'b001};
        tbl[21] = '{4'h1, 16'h1234, 16'h1234, 16'h0000, 3'b010};

        // Reset state
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 16'h0000);
        check("rst_flags", flags, 3'b000);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Vector table, back to back
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].r, tbl[i].f);
            mflags = tbl[i].f;
        end
        #1 in_valid = 1'b0;
        drain();

        // RED timing: busy the cycle after accept, result after the next edge
        issue_m(4'h3, 16'h7F7F, 16'h7F7F);
        #1 in_valid = 1'b0;
        check("red_busy_in_ready", in_ready, 0);
        check("red_early_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("red_out_valid", out_valid, 1);
        check("red_result", result, 16'h01FC);
        check("red_flags_hold", flags, 3'b010);
        drain();

        // Backpressure: completed XOR holds while a second op waits
        @(negedge clk);
        out_ready = 1'b0;
        issue_m(4'h2, 16'h1234, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            opcode   = 4'h0;
            A        = 16'h0001;
            B        = 16'h0001;
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_result", result, 16'h0000);
            check("stall_z", flags[1], 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        model(4'h0, 16'h0001, 16'h0001, mflags, r, f);
        @(posedge clk);
        sb.push_back('{r: r, f: f});
        mflags = f;
        #1;
        in_valid = 1'b0;
        check("release_out_valid", out_valid, 1);
        drain();

        // Back-to-back shifts, one per cycle
        issue_m(4'h4, 16'h0001, 16'h000F);
        a0 = acc_cyc;
        issue_m(4'h5, 16'h8000, 16'h0004);
        #1 check("b2b_out_valid_1", out_valid, 1);
        issue_m(4'h6, 16'h0001, 16'h0001);
        #1 check("b2b_out_valid_2", out_valid, 1);
        in_valid = 1'b0;
        check("b2b_accept_spacing", acc_cyc - a0, 2);
        drain();

        // Reset while in RED2: nothing emitted
        issue(4'h3, 16'h7F7F, 16'h7F7F, 1'b0, '0, '0);
        #1 in_valid = 1'b0;
        check("red2_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midred_rst_out_valid", out_valid, 0);
        check("midred_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midred_after_out_valid", out_valid, 0);
        check("midred_after_in_ready", in_ready, 1);
        check("midred_after_result", result, 16'h0000);
        check("midred_after_flags", flags, 3'b000);
        mflags = '0;
        issue_m(4'h0, 16'h0001, 16'h0002);
        #1 in_valid = 1'b0;
        drain();

        // Random ops with random backpressure
        bp = 1'b1;
        repeat (40) begin
            rop = 4'($urandom_range(0, 8));
            issue_m(rop, 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                #1 in_valid = 1'b0;
                @(posedge clk);
            end
        end
        bp = 1'b0;
        #1 in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
